// File: rtl/rc5_core.sv
// RC5-W/R/B block cipher core: iterative key expansion into an S table,
// then one full round per cycle for encrypt or decrypt.
module rc5_core #(
  parameter int unsigned    W  = 32,
  parameter int unsigned    R  = 12,
  parameter int unsigned    B  = 16,
  parameter logic [W-1:0]   PW = 'hB7E15163,
  parameter logic [W-1:0]   QW = 'h9E3779B9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [8*B-1:0]   key_in,
  output logic             key_ready,
  input  logic             mode,
  input  logic             start,
  input  logic [W-1:0]     iA,
  input  logic [W-1:0]     iB,
  output logic             busy,
  output logic [W-1:0]     oA,
  output logic [W-1:0]     oB,
  output logic             done
);

  localparam int unsigned T    = 2 * (R + 1);
  localparam int unsigned U    = W / 8;
  localparam int unsigned C    = (B + U - 1) / U;
  localparam int unsigned NMIX = 3 * ((T > C) ? T : C);
  localparam int unsigned TW   = $clog2(T);
  localparam int unsigned CW   = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned MW   = $clog2(NMIX + 1);
  localparam int unsigned LW   = $clog2(W);
  localparam int unsigned KP   = 8 * C * U;

  typedef enum logic [2:0] {IDLE, KINIT, KMIX, CRUN, CFIN} state_t;

  state_t          state;
  logic [W-1:0]    s [T];
  logic [W-1:0]    l [C];
  logic [W-1:0]    ra, rb;
  logic [TW-1:0]   i, k;
  logic [CW-1:0]   j;
  logic [MW-1:0]   cnt;
  logic            dec, fin;
  logic            restart;
  logic [KP-1:0]   key_pad;
  logic [TW-1:0]   widx, wprev, se, so;
  logic [W-1:0]    mix_a, mix_ab, mix_b;
  logic [W-1:0]    ea, eb, da, db;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] n);
    logic [2*W-1:0] y;
    y = {x, x} << n;
    return y[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] n);
    logic [2*W-1:0] y;
    y = {x, x} >> n;
    return y[W-1:0];
  endfunction

  assign restart = key_load && (state == IDLE || state == KINIT || state == KMIX);
  assign key_pad = KP'(key_in);
  assign widx    = cnt[TW-1:0];
  assign wprev   = widx - TW'(1);
  assign se      = {k[TW-2:0], 1'b0};
  assign so      = {k[TW-2:0], 1'b1};

  always_comb begin
    mix_a  = rotl(s[i] + ra + rb, LW'(3));
    mix_ab = mix_a + rb;
    mix_b  = rotl(l[j] + mix_ab, mix_ab[LW-1:0]);
    ea     = rotl(ra ^ rb, rb[LW-1:0]) + s[se];
    eb     = rotl(rb ^ ea, ea[LW-1:0]) + s[so];
    db     = rotr(rb - s[so], ra[LW-1:0]) ^ ra;
    da     = rotr(ra - s[se], db[LW-1:0]) ^ db;
  end

  // Key tables carry no reset: key_ready gates every use of their contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (restart) begin
        s[0] <= PW;
        for (int unsigned m = 0; m < C; m++) l[m] <= key_pad[W*m +: W];
      end else if (state == KINIT) begin
        s[widx] <= s[wprev] + QW;
      end else if (state == KMIX && cnt != MW'(NMIX)) begin
        s[i] <= mix_a;
        l[j] <= mix_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      key_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      oA        <= '0;
      oB        <= '0;
      ra        <= '0;
      rb        <= '0;
      i         <= '0;
      j         <= '0;
      k         <= '0;
      cnt       <= '0;
      dec       <= 1'b0;
      fin       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (restart) begin
        state     <= KINIT;
        busy      <= 1'b1;
        key_ready <= 1'b0;
        cnt       <= MW'(1);
        ra        <= '0;
        rb        <= '0;
        i         <= '0;
        j         <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && key_ready) begin
              dec   <= mode;
              ra    <= mode ? iA : iA + s[0];
              rb    <= mode ? iB : iB + s[1];
              k     <= mode ? TW'(R) : TW'(1);
              busy  <= 1'b1;
              state <= CRUN;
            end
          end
          KINIT: begin
            if (widx == TW'(T - 1)) begin
              cnt   <= '0;
              state <= KMIX;
            end else begin
              cnt <= cnt + MW'(1);
            end
          end
          KMIX: begin
            if (cnt == MW'(NMIX)) begin
              key_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              ra  <= mix_a;
              rb  <= mix_b;
              i   <= (i == TW'(T - 1)) ? '0 : i + TW'(1);
              j   <= (j == CW'(C - 1)) ? '0 : j + CW'(1);
              cnt <= cnt + MW'(1);
            end
          end
          CRUN: begin
            ra <= dec ? da : ea;
            rb <= dec ? db : eb;
            if (k == (dec ? TW'(1) : TW'(R))) begin
              fin   <= 1'b0;
              state <= CFIN;
            end else begin
              k <= dec ? k - TW'(1) : k + TW'(1);
            end
          end
          CFIN: begin
            // Two cycles here: final whitening step, then the output register,
            // so done lands R+2 edges after accept in both modes.
            if (!fin) begin
              if (dec) begin
                ra <= ra - s[0];
                rb <= rb - s[1];
              end
              fin <= 1'b1;
            end else begin
              oA    <= ra;
              oB    <= rb;
              done  <= 1'b1;
              busy  <= 1'b0;
              fin   <= 1'b0;
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc5_core.sv
// Directed bench for rc5_core (W=32, R=12, B=16) using published RC5 vectors
// plus sequences for guarding, re-keying and reset corner cases.
module tb_rc5_core;
  localparam int W = 32;
  localparam int R = 12;
  localparam int B = 16;
  localparam logic [127:0] KEY0 = '0;
  localparam logic [127:0] KEYK = 128'h91CEA91001A5556351B241BE19465F91;

  logic           clk = 1'b0;
  logic           rst;
  logic           key_load;
  logic [127:0]   key_in;
  logic           key_ready;
  logic           mode;
  logic           start;
  logic [W-1:0]   iA, iB, oA, oB;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  rc5_core #(.W(W), .R(R), .B(B)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
    .key_ready(key_ready), .mode(mode), .start(start), .iA(iA), .iB(iB),
    .busy(busy), .oA(oA), .oB(oB), .done(done)
  );

  typedef struct {
    logic [127:0] key;
    logic         m;
    logic [31:0]  a, b, ea, eb;
  } vec_t;

  vec_t vecs [4];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where key_ready is first seen.
  task automatic expand(input logic [127:0] key, input logic with_start);
    int n;
    int dones;
    key_in = key; key_load = 1'b1; start = with_start; mode = 1'b0; iA = '0; iB = '0;
    @(negedge clk);
    key_load = 1'b0; start = 1'b0;
    check("key_ready_drop", key_ready, 0);
    check("busy_expand", busy, 1);
    n = 0; dones = 0;
    while (!key_ready && n < 300) begin
      @(negedge clk);
      n++;
      if (done) dones++;
    end
    check("expand_latency", n, 104);
    check("expand_no_done", dones, 0);
    check("busy_after_expand", busy, 0);
  endtask

  // Called at a negedge; returns at the negedge where done is first seen.
  task automatic run_block(input logic m, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ea, input logic [31:0] eb);
    int n;
    mode = m; iA = a; iB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; iA = '1; iB = '1;
    check("busy_block", busy, 1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("block_latency", n, R + 2);
    check("block_oA", oA, ea);
    check("block_oB", oB, eb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    int first;
    logic [127:0] cur_key;
    logic have_key;

    vecs[0] = '{KEY0, 1'b0, 32'h00000000, 32'h00000000, 32'hEEDBA521, 32'h6D8F4B15};
    vecs[1] = '{KEY0, 1'b1, 32'hEEDBA521, 32'h6D8F4B15, 32'h00000000, 32'h00000000};
    vecs[2] = '{KEYK, 1'b0, 32'hEEDBA521, 32'h6D8F4B15, 32'hAC13C0F7, 32'h52892B5B};
    vecs[3] = '{KEYK, 1'b1, 32'hAC13C0F7, 32'h52892B5B, 32'hEEDBA521, 32'h6D8F4B15};

    rst = 1'b0; key_load = 1'b0; key_in = '0; mode = 1'b0; start = 1'b0; iA = '0; iB = '0;
    repeat (3) @(negedge clk);
    check("rst_key_ready", key_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_oA", oA, 0);
    check("rst_oB", oB, 0);
    rst = 1'b1;
    @(negedge clk);

    // Start with no key expanded must be ignored.
    iA = 32'h12345678; iB = 32'h9ABCDEF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("nokey_no_done", dones, 0);
    check("nokey_busy", busy, 0);
    check("nokey_oA", oA, 0);

    // Table vectors; same-key entries run back-to-back.
    have_key = 1'b0;
    cur_key = '0;
    for (int v = 0; v < 4; v++) begin
      if (!have_key || vecs[v].key != cur_key) begin
        expand(vecs[v].key, 1'b0);
        cur_key = vecs[v].key;
        have_key = 1'b1;
      end
      run_block(vecs[v].m, vecs[v].a, vecs[v].b, vecs[v].ea, vecs[v].eb);
    end

    // Start while busy in CRUN is ignored; outputs hold after done.
    mode = 1'b0; iA = 32'hEEDBA521; iB = 32'h6D8F4B15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; first = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 3) begin start = 1'b1; iA = '0; iB = '0; end
      else start = 1'b0;
      if (done) begin
        dones++;
        if (first == 0) first = c;
      end
    end
    check("busy_start_first_done", first, R + 2);
    check("busy_start_done_count", dones, 1);
    check("hold_oA", oA, 32'hAC13C0F7);
    check("hold_oB", oB, 32'h52892B5B);

    // key_load during CRUN is ignored; block completes with the old key.
    mode = 1'b1; iA = 32'hAC13C0F7; iB = 32'h52892B5B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 4) begin key_load = 1'b1; key_in = KEY0; end
      else key_load = 1'b0;
      if (done) begin
        dones++;
        if (first == 0) first = c;
      end
    end
    check("crun_keyload_latency", first, R + 2);
    check("crun_keyload_oA", oA, 32'hEEDBA521);
    check("crun_keyload_oB", oB, 32'h6D8F4B15);
    check("crun_keyload_ready", key_ready, 1);
    check("crun_keyload_busy", busy, 0);
    run_block(1'b0, 32'hEEDBA521, 32'h6D8F4B15, 32'hAC13C0F7, 32'h52892B5B);

    // key_load and start on the same IDLE edge: expansion wins, no block.
    expand(KEY0, 1'b1);
    run_block(1'b0, 32'h0, 32'h0, 32'hEEDBA521, 32'h6D8F4B15);

    // Re-key during KMIX: latency restarts and the second key is used.
    key_in = KEY0; key_load = 1'b1;
    @(negedge clk);
    key_load = 1'b0;
    repeat (40) @(negedge clk);
    check("rekey_not_ready", key_ready, 0);
    expand(KEYK, 1'b0);
    run_block(1'b0, 32'hEEDBA521, 32'h6D8F4B15, 32'hAC13C0F7, 32'h52892B5B);

    // Reset during CRUN: immediate clear, no done, key must be re-expanded.
    mode = 1'b0; iA = 32'hEEDBA521; iB = 32'h6D8F4B15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_oA", oA, 0);
    check("midrst_oB", oB, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_key_ready", key_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    iA = 32'hEEDBA521; iB = 32'h6D8F4B15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("postrst_no_done", dones, 0);
    check("postrst_busy", busy, 0);
    expand(KEYK, 1'b0);
    run_block(1'b0, 32'hEEDBA521, 32'h6D8F4B15, 32'hAC13C0F7, 32'h52892B5B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rc5_core.md
RC5_CORE -- requirements
Module: rc5_core

Interface
REQ-001 SHALL expose parameter W, default 32, word width in bits; legal values are 16, 32 and 64.
REQ-002 SHALL expose parameter R, default 12, round count; legal range is 1..255.
REQ-003 SHALL expose parameter B, default 16, key length in bytes; legal range is 1..32.
REQ-004 SHALL expose parameters PW and QW, default 32'hB7E15163 and 32'h9E3779B9, the W-bit magic constants.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port key_load, input, 1 bit: pulse that starts key expansion.
REQ-008 SHALL have port key_in, input, 8*B bits: key byte i is key_in[8i+:8].
REQ-009 SHALL have port key_ready, output, 1 bit: S table valid.
REQ-010 SHALL have port mode, input, 1 bit: 0 = encrypt, 1 = decrypt; sampled with start.
REQ-011 SHALL have port start, input, 1 bit: block request.
REQ-012 SHALL have ports iA and iB, input, W bits each: input block words.
REQ-013 SHALL have port busy, output, 1 bit: key expansion or block operation in progress.
REQ-014 SHALL have ports oA and oB, output, W bits each: result words.
REQ-015 SHALL have port done, output, 1 bit: one-cycle result-valid pulse.

Function
REQ-016 SHALL derive t = 2(R+1), u = W/8 and c = max(1, ceil(B/u)).
REQ-017 SHALL hold internal arrays S[0..t-1] and L[0..c-1] of W bits each.
REQ-018 SHALL pack L from key_in little-endian, with byte k going to L[k/u] bits [8(k mod u)+:8] and unused bytes zero.
REQ-019 SHALL use an FSM with states IDLE, KINIT, KMIX, CRUN and CFIN.
REQ-020 SHALL, on a key_load edge in IDLE or KINIT or KMIX, load L, set S[0]=PW, clear the A/B/i/j mix registers, drop key_ready and enter KINIT.
REQ-021 SHALL in KINIT write one entry per cycle, S[n]=S[n-1]+QW mod 2^W for n=1..t-1, then enter KMIX.
REQ-022 SHALL in KMIX perform one iteration per cycle for exactly 3*max(t,c) cycles:
- A=S[i]=(S[i]+A+B)<<<3
- B=L[j]=(L[j]+A+B)<<<((A+B) mod W)
- i=(i+1) mod t
- j=(j+1) mod c
REQ-023 SHALL, when KMIX completes, set key_ready=1 and return to IDLE; total expansion latency is t-1+3*max(t,c)+1 cycles after the key_load edge (104 cycles for W=32, R=12, B=16).
REQ-024 SHALL accept start only in IDLE with key_ready=1, latching iA, iB and mode; start is ignored otherwise and produces no done.
REQ-025 SHALL in encrypt mode perform, on the accept edge, A=iA+S[0] and B=iB+S[1], then one full round per CRUN cycle for k=1..R: A=((A^B)<<<B)+S[2k]; B=((B^A)<<<A)+S[2k+1].
REQ-026 SHALL in decrypt mode latch iA and iB on the accept edge, then one round per CRUN cycle for k=R..1: B=((B-S[2k+1])>>>A)^A; A=((A-S[2k])>>>B)^B.
REQ-027 SHALL in decrypt mode apply B-=S[1] and A-=S[0] in CFIN.
REQ-028 SHALL in encrypt mode make CFIN a pure register stage.
REQ-029 SHALL reduce all arithmetic mod 2^W and take rotate amounts as the low log2(W) bits.
REQ-030 SHALL update oA and oB and pulse done exactly R+2 cycles after the start accept edge, for both modes.
REQ-031 SHALL hold oA and oB stable until the next done.
REQ-032 SHALL hold busy=1 in KINIT, KMIX, CRUN and CFIN, and busy=0 in IDLE.
REQ-033 SHALL ignore key_load while in CRUN or CFIN; the block finishes with the old key.
REQ-034 SHALL restart expansion on key_load during KINIT or KMIX; the partial table is discarded and key_ready stays 0.
REQ-035 SHALL, on start and key_load on the same edge in IDLE, give key_load priority and ignore start.
REQ-036 SHALL accept back-to-back blocks, with start taken on the cycle after done.

Reset
REQ-037 SHALL while rst=0 force state IDLE; key_ready, busy and done to 0; oA and oB to 0; and the counters and mix registers to 0, asynchronously.
REQ-038 SHALL on reset mid-operation abort any expansion or block with no done pulse; a new key_load is required before any start is accepted.

Verification
REQ-039 SHALL cover zero key: W=32, R=12, B=16, key_in=0, expand, then encrypt iA=0, iB=0 -> oA=EEDBA521, oB=6D8F4B15, done at accept+14.
REQ-040 SHALL cover a nonzero key: key_in=128'h91CEA91001A5556351B241BE19465F91, encrypt iA=EEDBA521, iB=6D8F4B15 -> oA=AC13C0F7, oB=52892B5B.
REQ-041 SHALL cover decrypt with the same key: iA=AC13C0F7, iB=52892B5B -> oA=EEDBA521, oB=6D8F4B15, confirming round trip.
REQ-042 SHALL cover guarding: start before key_ready, and start while busy -> no done, outputs unchanged; key_ready rises exactly 104 cycles after key_load.
REQ-043 SHALL cover reset mid-operation: rst low during CRUN -> immediate zero outputs, no done; start after release ignored until re-expansion.
REQ-044 SHALL cover re-key mid-expansion: key_load again during KMIX -> key_ready 104 cycles after the second pulse; ciphertext matches the second key.
